// File: rtl/opencode_if.sv
// opencode_if: host staging/commit port and opcode stream port of the opcode encoder
interface opencode_if #(
   parameter int FIFO_DEPTH = 4
) ();
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic          wr_en;
   logic [2:0]    wr_sel;
   logic [18:0]   wr_data;
   logic          commit;
   logic [3:0]    commit_shape;
   logic          cmd_accepted;
   logic          cmd_error;
   logic [1:0]    err_code;
   logic [95:0]   opcode;
   logic          opcode_valid;
   logic          opcode_ready;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   modport master (
      output wr_en, wr_sel, wr_data, commit, commit_shape, opcode_ready,
      input  cmd_accepted, cmd_error, err_code, opcode, opcode_valid, fifo_count, fifo_full
   );
   modport slave (
      input  wr_en, wr_sel, wr_data, commit, commit_shape, opcode_ready,
      output cmd_accepted, cmd_error, err_code, opcode, opcode_valid, fifo_count, fifo_full
   );
endinterface

// File: rtl/opencode.sv
// opencode: packs staged draw fields into 96-bit opcodes queued in a first-word-fall-through FIFO
module opencode #(
   parameter int FIFO_DEPTH      = 4,
   parameter int NUM_SHAPES      = 3,
   parameter bit CLEAR_ON_COMMIT = 1'b0
) (
   input logic       clk,
   input logic       n_rst,
   opencode_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);
   localparam logic [4:0]    SHAPES = 5'(NUM_SHAPES);

   logic [15:0]   color;
   logic [18:0]   pt [4];
   logic [95:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          accepted;
   logic          error;
   logic [1:0]    err;
   logic          shape_bad;
   logic          full;
   logic          pop;
   logic          overflow;
   logic          push;
   logic [95:0]   packed_word;

   // Commit qualification: shape legality first, then room (a same-edge pop frees a slot)
   always_comb begin
      shape_bad   = {1'b0, bus.commit_shape} >= SHAPES;
      full        = count == DEPTH;
      pop         = (count != '0) & bus.opcode_ready;
      overflow    = full & ~pop;
      push        = bus.commit & ~shape_bad & ~overflow;
      packed_word = {bus.commit_shape, color, pt[0], pt[1], pt[2], pt[3]};
   end

   // Staging registers; a same-edge field write overrides the post-commit clear
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         color <= '0;
         for (int i = 0; i < 4; i++) pt[i] <= '0;
      end else begin
         if (CLEAR_ON_COMMIT && push) begin
            color <= '0;
            for (int i = 0; i < 4; i++) pt[i] <= '0;
         end
         if (bus.wr_en) begin
            if (bus.wr_sel == 3'd0) color <= bus.wr_data[15:0];
            for (int i = 0; i < 4; i++)
               if (bus.wr_sel == 3'(i + 1)) pt[i] <= bus.wr_data;
         end
      end
   end

   // FIFO storage, wrapping pointers and occupancy count
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= packed_word;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Commit status pulses; the error code is held until the next commit
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         accepted <= 1'b0;
         error    <= 1'b0;
         err      <= 2'b00;
      end else begin
         accepted <= push;
         error    <= bus.commit & ~push;
         if (bus.commit) err <= shape_bad ? 2'b01 : overflow ? 2'b10 : 2'b00;
      end
   end

   assign bus.cmd_accepted = accepted;
   assign bus.cmd_error    = error;
   assign bus.err_code     = err;
   assign bus.opcode       = mem[rd_ptr];
   assign bus.opcode_valid = count != '0;
   assign bus.fifo_count   = count;
   assign bus.fifo_full    = full;
endmodule

// File: tb/tb_opencode.sv
// tb_opencode: directed scenario tests of the opcode encoder
module tb_opencode;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   checks = 0;
   int   fails = 0;

   opencode_if #(.FIFO_DEPTH(4)) bus ();

   opencode #(.FIFO_DEPTH(4), .NUM_SHAPES(3), .CLEAR_ON_COMMIT(1'b0)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   localparam logic [95:0] E_BASIC = {4'h0, 16'hFFFF, 19'h00000, 19'h7FFFF, 19'h00000, 19'h7FFFF};
   localparam logic [95:0] E_SEL5  = {4'h1, 16'hFFFF, 19'h00123, 19'h7FFFF, 19'h00000, 19'h7FFFF};
   localparam logic [95:0] E_ZERO2 = {4'h2, 92'd0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_field(input logic [2:0] sel, input logic [18:0] data);
      bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
      step();
      bus.wr_en = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] shape);
      bus.commit = 1'b1; bus.commit_shape = shape;
      step();
      bus.commit = 1'b0;
   endtask

   task automatic pop_one();
      bus.opcode_ready = 1'b1;
      step();
      bus.opcode_ready = 1'b0;
   endtask

   task automatic test_reset();
      step(); step();
      checks++; if (bus.opcode_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.opcode_valid); end
      checks++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
      checks++; if (bus.opcode !== 96'd0) begin fails++; $display("FAIL reset_opcode got %h want 0", bus.opcode); end
      checks++; if ({bus.cmd_accepted, bus.cmd_error, bus.err_code} !== 4'b0) begin fails++; $display("FAIL reset_status got %b want 0000", {bus.cmd_accepted, bus.cmd_error, bus.err_code}); end
      checks++; if (bus.fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", bus.fifo_full); end
      n_rst = 1'b1;
      step();
   endtask

   task automatic test_basic();
      write_field(3'd0, 19'h0FFFF);
      write_field(3'd1, 19'h00000);
      write_field(3'd2, 19'h7FFFF);
      write_field(3'd3, 19'h00000);
      write_field(3'd4, 19'h7FFFF);
      do_commit(4'h0);
      checks++; if (bus.opcode_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", bus.opcode_valid); end
      checks++; if (bus.opcode !== E_BASIC) begin fails++; $display("FAIL basic_opcode got %h want %h", bus.opcode, E_BASIC); end
      checks++; if (bus.cmd_accepted !== 1'b1 || bus.cmd_error !== 1'b0) begin fails++; $display("FAIL basic_accept got acc=%b err=%b want 1 0", bus.cmd_accepted, bus.cmd_error); end
      checks++; if (bus.fifo_count !== 3'd1) begin fails++; $display("FAIL basic_count got %0d want 1", bus.fifo_count); end
      pop_one();
      checks++; if (bus.opcode_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin fails++; $display("FAIL basic_pop got valid=%b count=%0d want 0 0", bus.opcode_valid, bus.fifo_count); end
      checks++; if (bus.cmd_accepted !== 1'b0) begin fails++; $display("FAIL basic_pulse got %b want 0", bus.cmd_accepted); end
   endtask

   task automatic test_bad_shape();
      logic [3:0] shapes [2] = '{4'h3, 4'hF};
      for (int i = 0; i < 2; i++) begin
         do_commit(shapes[i]);
         checks++; if (bus.cmd_error !== 1'b1 || bus.cmd_accepted !== 1'b0) begin fails++; $display("FAIL bad_shape_%0d got err=%b acc=%b want 1 0", i, bus.cmd_error, bus.cmd_accepted); end
         checks++; if (bus.err_code !== 2'b01) begin fails++; $display("FAIL bad_shape_code_%0d got %b want 01", i, bus.err_code); end
         checks++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL bad_shape_count_%0d got %0d want 0", i, bus.fifo_count); end
      end
      step();
      checks++; if (bus.err_code !== 2'b01 || bus.cmd_error !== 1'b0) begin fails++; $display("FAIL bad_shape_hold got code=%b err=%b want 01 0", bus.err_code, bus.cmd_error); end
   endtask

   task automatic test_overflow();
      logic [3:0] shapes [5] = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h1};
      for (int i = 0; i < 4; i++) begin
         do_commit(shapes[i]);
         checks++; if (bus.cmd_accepted !== 1'b1) begin fails++; $display("FAIL ovf_accept_%0d got %b want 1", i, bus.cmd_accepted); end
      end
      checks++; if (bus.fifo_full !== 1'b1 || bus.fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_full got full=%b count=%0d want 1 4", bus.fifo_full, bus.fifo_count); end
      do_commit(shapes[4]);
      checks++; if (bus.cmd_error !== 1'b1 || bus.err_code !== 2'b10) begin fails++; $display("FAIL ovf_reject got err=%b code=%b want 1 10", bus.cmd_error, bus.err_code); end
      checks++; if (bus.fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d want 4", bus.fifo_count); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.opcode_valid !== 1'b1 || bus.opcode[95:92] !== shapes[i]) begin fails++; $display("FAIL ovf_order_%0d got valid=%b shape=%h want 1 %h", i, bus.opcode_valid, bus.opcode[95:92], shapes[i]); end
         pop_one();
      end
      checks++; if (bus.opcode_valid !== 1'b0) begin fails++; $display("FAIL ovf_drained got %b want 0", bus.opcode_valid); end
   endtask

   task automatic test_full_pop();
      logic [3:0] shapes [4] = '{4'h0, 4'h1, 4'h0, 4'h2};
      for (int i = 0; i < 3; i++) do_commit(shapes[i]);
      do_commit(4'h1);
      bus.opcode_ready = 1'b1;
      do_commit(4'h2);
      bus.opcode_ready = 1'b0;
      checks++; if (bus.cmd_accepted !== 1'b1 || bus.err_code !== 2'b00) begin fails++; $display("FAIL fullpop_accept got acc=%b code=%b want 1 00", bus.cmd_accepted, bus.err_code); end
      checks++; if (bus.fifo_count !== 3'd4 || bus.fifo_full !== 1'b1) begin fails++; $display("FAIL fullpop_count got %0d full=%b want 4 1", bus.fifo_count, bus.fifo_full); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.opcode[95:92] !== (i == 3 ? 4'h2 : i == 2 ? 4'h1 : shapes[i + 1])) begin fails++; $display("FAIL fullpop_order_%0d got %h", i, bus.opcode[95:92]); end
         pop_one();
      end
   endtask

   task automatic test_same_cycle_write();
      bus.wr_en = 1'b1; bus.wr_sel = 3'd1; bus.wr_data = 19'h00123;
      do_commit(4'h1);
      bus.wr_en = 1'b0;
      checks++; if (bus.opcode[75:57] !== 19'h0) begin fails++; $display("FAIL same_cycle_p0 got %h want 0", bus.opcode[75:57]); end
      pop_one();
      do_commit(4'h1);
      checks++; if (bus.opcode[75:57] !== 19'h00123) begin fails++; $display("FAIL next_commit_p0 got %h want 00123", bus.opcode[75:57]); end
      pop_one();
      write_field(3'd5, 19'h55555);
      write_field(3'd7, 19'h2AAAA);
      do_commit(4'h1);
      checks++; if (bus.opcode !== E_SEL5) begin fails++; $display("FAIL ignored_sel got %h want %h", bus.opcode, E_SEL5); end
      pop_one();
   endtask

   task automatic test_async_reset();
      do_commit(4'h0); do_commit(4'h1); do_commit(4'h2);
      checks++; if (bus.fifo_count !== 3'd3) begin fails++; $display("FAIL arst_pre_count got %0d want 3", bus.fifo_count); end
      #2 n_rst = 1'b0;
      #1;
      checks++; if (bus.opcode_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin fails++; $display("FAIL arst_clear got valid=%b count=%0d want 0 0", bus.opcode_valid, bus.fifo_count); end
      checks++; if (bus.opcode !== 96'd0 || bus.cmd_accepted !== 1'b0) begin fails++; $display("FAIL arst_opcode got %h acc=%b want 0 0", bus.opcode, bus.cmd_accepted); end
      #1 n_rst = 1'b1;
      step();
      do_commit(4'h2);
      checks++; if (bus.opcode !== E_ZERO2 || bus.opcode_valid !== 1'b1) begin fails++; $display("FAIL arst_commit got %h valid=%b want %h 1", bus.opcode, bus.opcode_valid, E_ZERO2); end
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_sel = 3'd0; bus.wr_data = '0;
      bus.commit = 1'b0; bus.commit_shape = 4'h0; bus.opcode_ready = 1'b0;
      test_reset();
      test_basic();
      test_bad_shape();
      test_overflow();
      test_full_pop();
      test_same_cycle_write();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
